// File: rtl/arb4_rr_ctrl_pkg.sv
// Shared definitions for the four-way round-robin arbiter: payload width,
// requester count, FSM state encoding and a one-hot grant helper.
package arb4_rr_ctrl_pkg;

  localparam int ARCH_WIDTH = 32;
  localparam int ARB_N_REQ  = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [ARB_N_REQ-1:0] arb_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/arb4_rr_ctrl_pick.sv
// rr_pick4: combinational rotating-priority picker. Returns the first set
// request bit starting at ptr and wrapping modulo 4.
module rr_pick4
  import arb4_rr_ctrl_pkg::*;
(
  input  logic [ARB_N_REQ-1:0] req,
  input  logic [1:0]           ptr,
  output logic                 any,
  output logic [1:0]           idx
);

  logic [1:0] cand;

  // Walk from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    any  = |req;
    idx  = 2'd0;
    cand = 2'd0;
    for (int k = ARB_N_REQ - 1; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/arb4_rr_ctrl.sv
// Round-robin arbiter owning the select of a shared 4:1 datapath mux.
// Optional forced-release timeout enabled by defining ARB_TIMEOUT_EN.
module arb4_rr_ctrl
  import arb4_rr_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ARB_N_REQ-1:0]  req,
  input  logic [ARB_N_REQ-1:0]  done,
  input  logic [ARCH_WIDTH-1:0] data_in0,
  input  logic [ARCH_WIDTH-1:0] data_in1,
  input  logic [ARCH_WIDTH-1:0] data_in2,
  input  logic [ARCH_WIDTH-1:0] data_in3,
  output logic [ARB_N_REQ-1:0]  gnt,
  output logic [1:0]            sel,
  output logic                  busy,
  output logic [ARCH_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  timeout
);

  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("arb4_rr_ctrl: MAX_HOLD must be >= 2");
  end

  arb_state_e           state_q, state_d;
  logic [ARB_N_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]           sel_q, sel_d;
  logic [1:0]           ptr_q, ptr_d;
  logic                 pick_any;
  logic [1:0]           pick_idx;
  logic                 rel_normal;
  logic                 expire;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Holder release: its own done pulse or withdrawn request; others' done bits are ignored.
  assign rel_normal = done[sel_q] | ~req[sel_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d = ARB_GRANT;
          sel_d   = pick_idx;
          gnt_d   = arb_onehot(pick_idx);
        end
      end
      ARB_GRANT: begin
        if (rel_normal || expire) begin
          state_d = ARB_IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + 2'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  // Counter value equals GRANT cycles already completed by the holder.
  assign expire = (state_q == ARB_GRANT) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
    if (state_q == ARB_IDLE) begin
      hold_cnt_d = '0;
    end else if (!rel_normal) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
      timeout_d  = expire;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    case (sel_q)
      2'd0:    data_out = data_in0;
      2'd1:    data_out = data_in1;
      2'd2:    data_out = data_in2;
      default: data_out = data_in3;
    endcase
  end

  assign gnt        = gnt_q;
  assign sel        = sel_q;
  assign busy       = (state_q == ARB_GRANT);
  assign data_valid = busy;

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Randomized and directed bench for arb4_rr_ctrl against a behavioural
// round-robin reference model.
module tb_arb4_rr_ctrl;
  import arb4_rr_ctrl_pkg::*;

  localparam int MH = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [3:0]            req, done;
  logic [ARCH_WIDTH-1:0] din [4];
  logic [3:0]            gnt;
  logic [1:0]            sel;
  logic                  busy, data_valid, timeout;
  logic [ARCH_WIDTH-1:0] data_out;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: plain integers, no encoding shared with the design.
  int m_busy, m_sel, m_ptr, m_cycles, m_to;

  always #5 clk = ~clk;

  arb4_rr_ctrl #(.MAX_HOLD(MH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
    .data_in0   (din[0]),
    .data_in1   (din[1]),
    .data_in2   (din[2]),
    .data_in3   (din[3]),
    .gnt        (gnt),
    .sel        (sel),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .timeout    (timeout)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r_n, input logic [3:0] rq, input logic [3:0] dn);
    int idx;
    bit released, forced;
    if (!r_n) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_cycles = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (m_busy == 0) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (rq[idx]) begin
          m_sel = idx; m_busy = 1; m_cycles = 0;
          break;
        end
      end
    end else begin
      m_cycles = m_cycles + 1;
      released = dn[m_sel] || !rq[m_sel];
      forced = 0;
`ifdef ARB_TIMEOUT_EN
      forced = !released && (m_cycles >= MH);
`endif
      if (released || forced) begin
        m_busy = 0;
        m_ptr  = (m_sel + 1) % 4;
        m_to   = forced;
      end
    end
  endtask

  task automatic cycle(input logic r_n, input logic [3:0] rq, input logic [3:0] dn);
    logic [3:0] exp_gnt;
    rst_n = r_n; req = rq; done = dn;
    for (int i = 0; i < 4; i++) din[i] = $urandom;
    @(posedge clk);
    model_step(r_n, rq, dn);
    @(negedge clk);
    exp_gnt = m_busy ? (4'b0001 << m_sel) : 4'b0000;
    chk("gnt", 64'(gnt), 64'(exp_gnt));
    chk("sel", 64'(sel), 64'(m_sel));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("data_valid", 64'(data_valid), 64'(m_busy));
    chk("timeout", 64'(timeout), 64'(m_to));
    chk("data_out", 64'(data_out), 64'(din[m_sel]));
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] d;
    rst_n = 1'b0; req = '0; done = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    m_busy = 0; m_sel = 0; m_ptr = 0; m_cycles = 0; m_to = 0;

    // Reset state and single requester
    cycle(1'b0, 4'b0000, 4'b0000);
    chk("reset_gnt", 64'(gnt), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    cycle(1'b1, 4'b0001, 4'b0000);
    chk("t1_gnt", 64'(gnt), 64'h1);
    chk("t1_sel", 64'(sel), 64'h0);
    cycle(1'b1, 4'b0001, 4'b0001);
    chk("t1_release", 64'(gnt), 64'h0);

    // All requesting: order 0,1,2,3,0 with an idle cycle between grants
    cycle(1'b0, 4'b0000, 4'b0000);
    for (int g = 0; g < 5; g++) begin
      cycle(1'b1, 4'b1111, 4'b0000);
      chk("t2_order", 64'(gnt), 64'(4'b0001 << (g % 4)));
      cycle(1'b1, 4'b1111, 4'b0000);
      cycle(1'b1, 4'b1111, 4'(4'b0001 << (g % 4)));
      chk("t2_idle", 64'(gnt), 64'h0);
    end

    // Non-holder done ignored, then req drop releases and ptr moves to 3
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b1, 4'b0100, 4'b0000);
    cycle(1'b1, 4'b0100, 4'b0001);
    chk("t3_hold", 64'(gnt), 64'h4);
    cycle(1'b1, 4'b0000, 4'b0000);
    chk("t3_release", 64'(gnt), 64'h0);
    cycle(1'b1, 4'b1001, 4'b0000);
    chk("t3_ptr3", 64'(gnt), 64'h8);

    // Holder 3 releases with 0 and 3 pending: pointer wraps to 0
    cycle(1'b1, 4'b1001, 4'b1000);
    cycle(1'b1, 4'b1001, 4'b0000);
    chk("t4_wrap", 64'(gnt), 64'h1);

    // Reset mid-grant
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b1, 4'b0010, 4'b0000);
    chk("t5_gnt", 64'(gnt), 64'h2);
    cycle(1'b0, 4'b0010, 4'b0000);
    chk("t5_rst_gnt", 64'(gnt), 64'h0);
    chk("t5_rst_sel", 64'(sel), 64'h0);
    cycle(1'b1, 4'b0110, 4'b0000);
    chk("t5_regrant", 64'(gnt), 64'h2);

    // Holder never signals done
    cycle(1'b0, 4'b0000, 4'b0000);
    cycle(1'b1, 4'b0001, 4'b0000);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < MH - 1; i++) cycle(1'b1, 4'b0001, 4'b0000);
    chk("t6_still_held", 64'(busy), 64'h1);
    cycle(1'b1, 4'b0001, 4'b0000);
    chk("t6_forced", 64'(busy), 64'h0);
    chk("t6_timeout", 64'(timeout), 64'h1);
    cycle(1'b1, 4'b0000, 4'b0000);
    chk("t6_pulse_end", 64'(timeout), 64'h0);
`else
    for (int i = 0; i < 110; i++) cycle(1'b1, 4'b0001, 4'b0000);
    chk("t6_held", 64'(gnt), 64'h1);
    chk("t6_no_timeout", 64'(timeout), 64'h0);
`endif

    // Randomized traffic
    r = 4'b0000;
    for (int n = 0; n < 2000; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) r[b] = ~r[b];
        d[b] = ($urandom_range(5) == 0);
      end
      cycle(($urandom_range(99) != 0), r, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
